opc_bus_responder: RTL and testbench

OPC_BUS_RESPONDER -- requirements
Module: opc_bus_responder

---
 rtl/opc_bus_responder.sv | 192 +++++++++++++++++++
 tb/tb_opc_bus_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opc_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : opc_bus_responder
//  Purpose  : Memory and timer-interrupt IO responder for an OPC-style CPU bus,
//             with per-access wait states driven through a clock enable.
//  Revision : 1.0 - initial release
// ============================================================================
module opc_bus_responder #(
    parameter int            DW       = 16,
    parameter int            AW       = 16,
    parameter int            MEM_AW   = 12,
    parameter int            MEM_WAIT = 0,
    parameter int            IO_WAIT  = 1,
    parameter int            NUM_INT  = 2,
    parameter logic [AW-1:0] IO_BASE  = AW'(16'hFE00)
) (
    input  logic               clk,
    input  logic               reset_b,
    input  logic [AW-1:0]      address,
    input  logic               rnw,
    input  logic               vpa,
    input  logic               vda,
    input  logic               vio,
    input  logic [DW-1:0]      dout,
    output logic [DW-1:0]      din,
    output logic               clken,
    output logic [NUM_INT-1:0] int_b
);

    localparam int MAX_WAIT = (MEM_WAIT > IO_WAIT) ? MEM_WAIT : IO_WAIT;
    localparam int WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic           is_io, is_mem, is_acc;
    logic [WCW-1:0] n_wait;
    logic [1:0]     state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           clken_q, clken_d;
    logic           complete;

    always_comb begin
        is_io  = vio;
        is_mem = (vpa | vda) & ~vio;
        is_acc = is_io | is_mem;
        n_wait = is_io ? WCW'(IO_WAIT) : WCW'(MEM_WAIT);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            clken_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            clken_q <= clken_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (is_acc && (n_wait != '0)) begin
                    state_d = ST_WAIT;
                    wcnt_d  = n_wait - WCW'(1);
                end
            end
            ST_WAIT: begin
                if (wcnt_q != '0) wcnt_d  = wcnt_q - WCW'(1);
                else              state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // DONE always completes; what it does is decided by the bus as seen at that edge
    always_comb begin
        complete = 1'b0;
        clken_d  = clken_q;
        case (state_q)
            ST_IDLE: begin
                complete = is_acc && (n_wait == '0);
                clken_d  = !(is_acc && (n_wait != '0));
            end
            ST_WAIT: clken_d = (wcnt_q == '0);
            ST_DONE: begin
                complete = 1'b1;
                clken_d  = 1'b1;
            end
            default: clken_d = 1'b1;
        endcase
    end

    assign clken = clken_q;

    logic [DW-1:0]     mem [2**MEM_AW];
    logic [MEM_AW-1:0] mem_idx;
    logic              mem_we;
    logic [DW-1:0]     mem_rdata;

    assign mem_idx   = address[MEM_AW-1:0];
    assign mem_we    = complete & is_mem & ~rnw & reset_b;
    assign mem_rdata = mem[mem_idx];

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= dout;
    end

    logic [AW-1:0]      io_off;
    logic [AW-2:0]      io_chan;
    logic               io_hit, io_sel_status, io_wr;
    logic [DW-1:0]      io_rdata;
    logic [DW-1:0]      period_q [NUM_INT];
    logic [DW-1:0]      period_d [NUM_INT];
    logic [DW-1:0]      cnt_q    [NUM_INT];
    logic [DW-1:0]      cnt_d    [NUM_INT];
    logic [NUM_INT-1:0] pending_q, pending_d, int_b_q, int_b_d;
    logic [NUM_INT-1:0] per_wr, ack_wr, expire;
    logic [DW-1:0]      din_q, din_d;

    always_comb begin
        io_off        = address - IO_BASE;
        io_hit        = io_off < AW'(2 * NUM_INT);
        io_chan       = io_off[AW-1:1];
        io_sel_status = io_off[0];
        io_wr         = complete & is_io & ~rnw;
        io_rdata      = '0;
        for (int c = 0; c < NUM_INT; c++) begin
            if (io_hit && (io_chan == (AW-1)'(c))) begin
                io_rdata = io_sel_status ? {{(DW-1){1'b0}}, pending_q[c]} : period_q[c];
            end
        end
    end

    // A PERIOD write restarts the count and suppresses this edge's reload
    always_comb begin
        per_wr = '0;
        ack_wr = '0;
        expire = '0;
        for (int c = 0; c < NUM_INT; c++) begin
            per_wr[c]   = io_wr && io_hit && (io_chan == (AW-1)'(c)) && !io_sel_status;
            ack_wr[c]   = io_wr && io_hit && (io_chan == (AW-1)'(c)) && io_sel_status;
            period_d[c] = per_wr[c] ? dout : period_q[c];
            expire[c]   = !per_wr[c] && (period_q[c] != '0) && (cnt_q[c] == '0);
            if (per_wr[c])                cnt_d[c] = (dout == '0) ? '0 : dout - DW'(1);
            else if (period_q[c] == '0)   cnt_d[c] = '0;
            else if (cnt_q[c] == '0)      cnt_d[c] = period_q[c] - DW'(1);
            else                          cnt_d[c] = cnt_q[c] - DW'(1);
            pending_d[c] = expire[c] | (pending_q[c] & ~ack_wr[c]);
        end
        int_b_d = ~pending_q;
    end

    always_comb begin
        din_d = din_q;
        if (complete && rnw) begin
            if (is_io)       din_d = io_rdata;
            else if (is_mem) din_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int c = 0; c < NUM_INT; c++) begin
                period_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            pending_q <= '0;
            int_b_q   <= '1;
            din_q     <= '0;
        end else begin
            for (int c = 0; c < NUM_INT; c++) begin
                period_q[c] <= period_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            pending_q <= pending_d;
            int_b_q   <= int_b_d;
            din_q     <= din_d;
        end
    end

    assign din   = din_q;
    assign int_b = int_b_q;

endmodule
`default_nettype wire

// File: tb/tb_opc_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_opc_bus_responder
//  Purpose  : Randomised scoreboard bench for opc_bus_responder, two wait-state
//             configurations side by side against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_opc_bus_responder;

    localparam int          NI  = 2;
    localparam logic [15:0] IOB = 16'hFE00;

    typedef struct {
        longint      en;
        logic [15:0] val;
    } exp_t;

    logic clk = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int MW = (k == 1) ? 3 : 0;
        localparam int IW = (k == 1) ? 2 : 1;

        logic          reset_b = 1'b0;
        logic [15:0]   address = '0;
        logic          rnw = 1'b1, vpa = 1'b0, vda = 1'b0, vio = 1'b0;
        logic [15:0]   dout = '0;
        logic [15:0]   din;
        logic          clken;
        logic [NI-1:0] int_b;

        opc_bus_responder #(
            .DW(16), .AW(16), .MEM_AW(12), .MEM_WAIT(MW), .IO_WAIT(IW),
            .NUM_INT(NI), .IO_BASE(IOB)
        ) u_dut (
            .clk(clk), .reset_b(reset_b), .address(address), .rnw(rnw),
            .vpa(vpa), .vda(vda), .vio(vio), .dout(dout),
            .din(din), .clken(clken), .int_b(int_b)
        );

        // Access that completes at the coming edge, as published by the driver
        logic        comp_valid = 1'b0, comp_io = 1'b0, comp_rd = 1'b0;
        logic [15:0] comp_addr = '0, comp_data = '0;

        // Reference model: timers expire every PERIOD edges after their last write
        logic [15:0]   mem_m [int];
        logic [15:0]   per_m [NI];
        longint        lw_m  [NI];
        logic [NI-1:0] pend_m = '0;
        logic [NI-1:0] intb_m = '1;
        logic [15:0]   din_m  = '0;
        longint        ecount = 0;
        exp_t          exp_q [$];
        int            wr_list [$];
        logic          drv_done = 1'b0;

        always @(posedge clk or negedge reset_b) begin : model
            logic [15:0]   off, val;
            logic [NI-1:0] ack;
            int            ch;
            logic          ex;
            exp_t          e;
            if (!reset_b) begin
                for (int c = 0; c < NI; c++) begin
                    per_m[c] = '0;
                    lw_m[c]  = 0;
                end
                pend_m = '0;
                intb_m = '1;
                din_m  = '0;
                exp_q.delete();
            end else begin
                intb_m = ~pend_m;
                ack    = '0;
                if (comp_valid) begin
                    val = '0;
                    if (comp_io) begin
                        off = comp_addr - IOB;
                        if (off < 16'(2 * NI)) begin
                            ch = int'(off[15:1]);
                            if (comp_rd)     val = off[0] ? {15'd0, pend_m[ch]} : per_m[ch];
                            else if (off[0]) ack[ch] = 1'b1;
                            else begin
                                per_m[ch] = comp_data;
                                lw_m[ch]  = ecount;
                            end
                        end
                    end else if (comp_rd) begin
                        val = mem_m[int'(comp_addr[11:0])];
                    end else begin
                        mem_m[int'(comp_addr[11:0])] = comp_data;
                    end
                    if (comp_rd) begin
                        din_m = val;
                        e.en  = ecount;
                        e.val = val;
                        exp_q.push_back(e);
                    end
                end
                for (int c = 0; c < NI; c++) begin
                    ex = 1'b0;
                    if (per_m[c] != 16'd0 && ecount > lw_m[c])
                        ex = ((ecount - lw_m[c]) % longint'(per_m[c])) == 0;
                    if (ex)          pend_m[c] = 1'b1;
                    else if (ack[c]) pend_m[c] = 1'b0;
                end
                ecount++;
            end
        end

        always @(negedge clk) begin : monitor
            exp_t e;
            if (reset_b) begin
                chk($sformatf("int_b inst%0d", k), 32'(int_b), 32'(intb_m));
                if (exp_q.size() > 0 && exp_q[0].en == ecount - 1) begin
                    e = exp_q.pop_front();
                    chk($sformatf("read_din inst%0d", k), 32'(din), 32'(e.val));
                end else begin
                    chk($sformatf("din_hold inst%0d", k), 32'(din), 32'(din_m));
                end
            end
        end

        task automatic put_bus(input logic io, input logic rd, input logic [15:0] a, input logic [15:0] d);
            address = a;
            rnw     = rd;
            dout    = d;
            vio     = io;
            vpa     = 1'($urandom_range(0, 1));
            vda     = (io || vpa) ? 1'($urandom_range(0, 1)) : 1'b1;
        endtask

        task automatic set_comp(input logic io, input logic rd, input logic [15:0] a, input logic [15:0] d);
            comp_io    = io;
            comp_rd    = rd;
            comp_addr  = a;
            comp_data  = d;
            comp_valid = 1'b1;
        endtask

        // Holds the access until the responder completes it; bus noise while stalled
        task automatic do_acc(input logic io, input logic rd, input logic [15:0] a, input logic [15:0] d);
            int n;
            int lows;
            n    = io ? IW : MW;
            lows = 0;
            put_bus(io, rd, a, d);
            if (n == 0) begin
                set_comp(io, rd, a, d);
                @(negedge clk);
                comp_valid = 1'b0;
                chk($sformatf("clken_no_wait inst%0d", k), 32'(clken), 32'd1);
            end else begin
                @(negedge clk);
                while (clken == 1'b0 && lows < 20) begin
                    lows++;
                    address = 16'($urandom);
                    dout    = 16'($urandom);
                    @(negedge clk);
                end
                address = a;
                dout    = d;
                set_comp(io, rd, a, d);
                @(negedge clk);
                comp_valid = 1'b0;
                chk($sformatf("clken_low_cycles inst%0d", k), 32'(lows), 32'(n));
            end
            if (!io && !rd) wr_list.push_back(int'(a[11:0]));
        endtask

        task automatic idle(input int n);
            vpa = 1'b0;
            vda = 1'b0;
            vio = 1'b0;
            repeat (n) @(negedge clk);
        endtask

        initial begin : driver
            int          r, ch, idx, off, t;
            logic [15:0] a;
            reset_b = 1'b0;
            repeat (3) @(negedge clk);
            chk($sformatf("reset_din inst%0d", k), 32'(din), 32'd0);
            chk($sformatf("reset_clken inst%0d", k), 32'(clken), 32'd1);
            chk($sformatf("reset_int_b inst%0d", k), 32'(int_b), 32'(2'b11));
            reset_b = 1'b1;
            idle(1);

            do_acc(1'b0, 1'b0, 16'h0010, 16'h1234);
            do_acc(1'b0, 1'b1, 16'h0010, 16'h0000);
            do_acc(1'b0, 1'b0, 16'h1005, 16'hBEEF);
            do_acc(1'b0, 1'b1, 16'h0005, 16'h0000);

            do_acc(1'b1, 1'b0, IOB, 16'd5);
            idle(8);
            do_acc(1'b1, 1'b0, IOB + 16'd1, 16'h0000);
            idle(3);
            // Time an ACK so that it completes on an expiry edge of channel 0
            off = (IW == 0) ? 0 : IW + 1;
            t   = 0;
            while (((ecount + longint'(off) - lw_m[0]) % 5) != 0 && t < 10) begin
                @(negedge clk);
                t++;
            end
            do_acc(1'b1, 1'b0, IOB + 16'd1, 16'h0000);
            idle(4);

            for (int i = 0; i < 300; i++) begin
                r = $urandom_range(0, 9);
                case (r)
                    0, 1, 2, 3: do_acc(1'b0, 1'b0, 16'($urandom), 16'($urandom));
                    4, 5: begin
                        if (wr_list.size() > 0) begin
                            idx = wr_list[$urandom_range(0, wr_list.size() - 1)];
                            a   = {4'($urandom), 12'(idx)};
                            do_acc(1'b0, 1'b1, a, 16'h0000);
                        end
                    end
                    6: begin
                        ch = $urandom_range(0, NI - 1);
                        if ($urandom_range(0, 1) == 1)
                            do_acc(1'b1, 1'b0, IOB + 16'(2 * ch), 16'($urandom_range(0, 12)));
                        else
                            do_acc(1'b1, 1'b0, IOB + 16'(2 * ch + 1), 16'($urandom));
                    end
                    7, 8: begin
                        r = $urandom_range(0, 5);
                        if (r < 4)       a = IOB + 16'(r);
                        else if (r == 4) a = IOB + 16'(2 * NI) + 16'($urandom_range(0, 7));
                        else             a = IOB - 16'd1;
                        if (r >= 4 && $urandom_range(0, 1) == 1)
                            do_acc(1'b1, 1'b0, a, 16'($urandom));
                        else
                            do_acc(1'b1, 1'b1, a, 16'h0000);
                    end
                    default: idle($urandom_range(1, 3));
                endcase
            end
            idle(2);

            // Reset in the middle of a stalled PERIOD1 write must abort it
            put_bus(1'b1, 1'b0, IOB + 16'd2, 16'h0007);
            @(negedge clk);
            chk($sformatf("stall_before_reset inst%0d", k), 32'(clken), 32'd0);
            #2 reset_b = 1'b0;
            #1;
            chk($sformatf("reset_abort_clken inst%0d", k), 32'(clken), 32'd1);
            chk($sformatf("reset_abort_int_b inst%0d", k), 32'(int_b), 32'(2'b11));
            @(negedge clk);
            idle(0);
            reset_b = 1'b1;
            do_acc(1'b1, 1'b1, IOB + 16'd2, 16'h0000);
            idle(3);
            drv_done = 1'b1;
        end
    end

    initial begin : finisher
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (g_inst[0].drv_done && g_inst[1].drv_done) break;
        end
        if (!(g_inst[0].drv_done && g_inst[1].drv_done)) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: drivers done=%0b%0b, required 11",
                     g_inst[1].drv_done, g_inst[0].drv_done);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
